frv_mem_responder: RTL and testbench

Memory-side responder for the frv core's imem/dmem request/response bus. Slave end of the interface the core drives as initiator. Accepts requests on req/gnt, performs reads/byte-strobed writes on an internal word-addressed SRAM, returns in-order responses on recv/ack. Used as behavioural memory behind each core instance in formal and simulation harnesses.

---
 rtl/frv_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_frv_mem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : frv_mem_responder
//  Description : Memory-side responder for the frv imem/dmem bus. Accepts
//                requests on mem_req/mem_gnt, performs reads and byte-strobed
//                writes on an internal word-addressed SRAM, and returns
//                in-order responses on mem_recv/mem_ack.
//
//  Ports       : g_clk      - clock, rising edge
//                g_resetn   - asynchronous active-low reset
//                mem_req    - request valid
//                mem_wen    - 1 = write, 0 = read
//                mem_strb   - byte write strobes
//                mem_wdata  - write data
//                mem_addr   - byte address
//                mem_gnt    - request accepted when high with mem_req
//                mem_recv   - response valid
//                mem_ack    - initiator accepts response
//                mem_error  - response error flag (valid with mem_recv)
//                mem_rdata  - read data (valid with mem_recv)
//
//  Options     : FRV_MEM_RESP_THROTTLE_EN - when defined, a 16-bit LFSR
//                randomly withholds grants and delays response presentation.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module frv_mem_responder #(
    parameter int          MEM_DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          LATENCY        = 1,
    parameter int          OUTSTANDING    = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic        mem_gnt,
    output logic        mem_recv,
    input  logic        mem_ack,
    output logic        mem_error,
    output logic [31:0] mem_rdata
);

    localparam int         c_DEPTH    = 1 << MEM_DEPTH_LOG2;
    localparam logic [2:0] c_OUTST    = 3'(OUTSTANDING);
    localparam logic [2:0] c_LAT_M1   = 3'(LATENCY - 1);
    localparam logic [1:0] c_LAST_PTR = 2'(OUTSTANDING - 1);

    // SRAM storage (never reset)
    logic [31:0] r_sram [c_DEPTH];

    // Response queue: circular buffer of {error, rdata, countdown}
    logic        r_q_err  [OUTSTANDING];
    logic [31:0] r_q_data [OUTSTANDING];
    logic [2:0]  r_q_cd   [OUTSTANDING];
    logic [1:0]  r_head;
    logic [2:0]  r_count;

    logic [29:0]               w_word;
    logic                      w_addr_ok;
    logic [MEM_DEPTH_LOG2-1:0] w_index;
    logic                      w_accept;
    logic                      w_pop;
    logic [2:0]                w_tail_sum;
    logic [1:0]                w_tail;
    logic [1:0]                w_head_next;
    logic                      w_head_ready;
    logic                      w_gnt_en;
    logic                      w_recv_en;

    // Word offset from the base. BASE_ADDR is word aligned, so subtracting
    // the word parts is the same as a 32-bit wrap-around byte subtraction
    // followed by a shift. Anything below the base wraps to a huge offset
    // and fails the range test.
    assign w_word    = mem_addr[31:2] - BASE_ADDR[31:2];
    assign w_addr_ok = (mem_addr[1:0] == 2'b00) && (w_word[29:MEM_DEPTH_LOG2] == '0);
    assign w_index   = w_word[MEM_DEPTH_LOG2-1:0];

    assign w_accept = mem_req & mem_gnt;
    assign w_pop    = mem_recv & mem_ack;

    // Free slot sits count entries past the head, modulo queue depth
    assign w_tail_sum  = {1'b0, r_head} + r_count;
    assign w_tail      = (w_tail_sum >= c_OUTST) ? 2'(w_tail_sum - c_OUTST) : w_tail_sum[1:0];
    assign w_head_next = (r_head == c_LAST_PTR) ? 2'd0 : r_head + 2'd1;

    assign w_head_ready = (r_count != 3'd0) && (r_q_cd[r_head] == 3'd0);

`ifdef FRV_MEM_RESP_THROTTLE_EN
    logic [15:0] r_lfsr;
    logic        r_shown;

    // Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // Remembers that the head is already on the bus so the LFSR cannot
    // withdraw a presented response before it is acknowledged.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_shown <= 1'b0;
        end else if (w_pop) begin
            r_shown <= 1'b0;
        end else if (mem_recv) begin
            r_shown <= 1'b1;
        end
    end

    assign w_gnt_en  = r_lfsr[0];
    assign w_recv_en = r_lfsr[1] | r_shown;
`else
    assign w_gnt_en  = 1'b1;
    assign w_recv_en = 1'b1;
`endif

    // Grant is forced low while reset is asserted
    assign mem_gnt   = g_resetn & (r_count < c_OUTST) & w_gnt_en;
    assign mem_recv  = w_head_ready & w_recv_en;
    assign mem_rdata = mem_recv ? r_q_data[r_head] : 32'd0;
    assign mem_error = mem_recv ? r_q_err[r_head]  : 1'b0;

    // Byte-strobed SRAM write at the accept edge
    always_ff @(posedge g_clk) begin
        if (w_accept && w_addr_ok && mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_strb[b]) begin
                    r_sram[w_index][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response queue
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_head  <= 2'd0;
            r_count <= 3'd0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                r_q_err[i]  <= 1'b0;
                r_q_data[i] <= 32'd0;
                r_q_cd[i]   <= 3'd0;
            end
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (r_q_cd[i] != 3'd0) begin
                    r_q_cd[i] <= r_q_cd[i] - 3'd1;
                end
            end

            // Tail slot is always free when accepting, so this overrides
            // nothing live in the decrement loop above.
            if (w_accept) begin
                r_q_cd[w_tail]   <= c_LAT_M1;
                r_q_err[w_tail]  <= ~w_addr_ok;
                r_q_data[w_tail] <= (w_addr_ok && !mem_wen) ? r_sram[w_index] : 32'd0;
            end

            if (w_pop) begin
                r_head <= w_head_next;
            end

            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frv_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frv_mem_responder
//  Description : Self-checking bench for frv_mem_responder. Table of single
//                transactions plus hand-written backpressure, throughput and
//                mid-flight reset sequences; responses checked via a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frv_mem_responder;

    localparam int c_LAT   = 1;
    localparam int c_OUTST = 2;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_wen = 1'b0;
    logic [3:0]  mem_strb = 4'h0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_addr = 32'd0;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack = 1'b0;
    logic        mem_error;
    logic [31:0] mem_rdata;

    frv_mem_responder #(
        .MEM_DEPTH_LOG2 (10),
        .BASE_ADDR      (32'h8000_0000),
        .LATENCY        (c_LAT),
        .OUTSTANDING    (c_OUTST)
    ) u_dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .mem_req   (mem_req),
        .mem_wen   (mem_wen),
        .mem_strb  (mem_strb),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_recv  (mem_recv),
        .mem_ack   (mem_ack),
        .mem_error (mem_error),
        .mem_rdata (mem_rdata)
    );

    always #5 g_clk = ~g_clk;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    exp_t  sb[$];
    vec_t  tbl[20];
    int    n_pass = 0;
    int    n_total = 0;
    exp_t  r_exp_next;
    logic  r_accepted;
    int    r_accepts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: score what the coming edge will accept/pop, then advance
    task automatic tick();
        exp_t e;
        if (mem_recv && mem_ack) begin
            if (sb.size() == 0) begin
                chk("spurious_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", mem_rdata, e.rdata);
                chk("resp_error", {31'd0, mem_error}, {31'd0, e.err});
            end
        end
        r_accepted = 1'b0;
        if (mem_req && mem_gnt) begin
            sb.push_back(r_exp_next);
            r_accepted = 1'b1;
            r_accepts++;
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic drive(input logic wen, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wdata, input logic err, input logic [31:0] rdata);
        mem_req    = 1'b1;
        mem_wen    = wen;
        mem_addr   = addr;
        mem_strb   = strb;
        mem_wdata  = wdata;
        r_exp_next = '{err: err, rdata: rdata};
    endtask

    // Single transaction with ack held high; checks grant, latency and data
    task automatic single(input vec_t v);
        int n;
        mem_ack = 1'b1;
        drive(v.wen, v.addr, v.strb, v.wdata, v.err, v.rdata);
        n = 0;
        do begin
            tick();
            n++;
        end while (!r_accepted && n < 20);
        mem_req = 1'b0;
        chk("granted", {31'd0, r_accepted}, 32'd1);
        // Accept edge just passed: recv must appear LATENCY cycles after
        // the request cycle, i.e. LATENCY-1 further edges from here.
        n = 0;
        while (!mem_recv && n < 20) begin
            tick();
            n++;
        end
        chk("latency", n, c_LAT - 1);
        tick();
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h8000_0010, 4'h5, 32'h1122_3344, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'hDE22_BE44};
        tbl[4]  = '{1'b1, 32'h8000_0014, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 32'h8000_0014, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 32'h8000_0014, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[7]  = '{1'b1, 32'h8000_0000, 4'hF, 32'h0102_0304, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 32'h8000_0FFC, 4'hF, 32'hA5A5_A5A5, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h8000_1000, 4'h0, 32'h0,         1'b1, 32'h0};
        tbl[10] = '{1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0,         1'b1, 32'h0};
        tbl[11] = '{1'b0, 32'h8000_0002, 4'h0, 32'h0,         1'b1, 32'h0};
        tbl[12] = '{1'b1, 32'h8000_1000, 4'hF, 32'h1234_5678, 1'b1, 32'h0};
        tbl[13] = '{1'b1, 32'h7FFF_FFFC, 4'hF, 32'h8765_4321, 1'b1, 32'h0};
        tbl[14] = '{1'b1, 32'h8000_0012, 4'hF, 32'h0BAD_0BAD, 1'b1, 32'h0};
        tbl[15] = '{1'b0, 32'h8000_0000, 4'h0, 32'h0,         1'b0, 32'h0102_0304};
        tbl[16] = '{1'b0, 32'h8000_0FFC, 4'h0, 32'h0,         1'b0, 32'hA5A5_A5A5};
        tbl[17] = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'hDE22_BE44};
        tbl[18] = '{1'b0, 32'h8000_0014, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D};
        tbl[19] = '{1'b0, 32'h8000_2000, 4'h0, 32'h0,         1'b1, 32'h0};
        r_exp_next = '0;
        r_accepted = 1'b0;
        r_accepts  = 0;

        // Reset and idle state
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
        chk("idle_gnt",   {31'd0, mem_gnt},   32'd1);
        chk("idle_recv",  {31'd0, mem_recv},  32'd0);
        chk("idle_rdata", mem_rdata,          32'd0);
        chk("idle_error", {31'd0, mem_error}, 32'd0);

        // Table of single transactions
        for (int i = 0; i < 20; i++) begin
            single(tbl[i]);
        end
        chk("table_drained", sb.size(), 0);

        // Backpressure: queue fills, third request is held off
        mem_ack = 1'b0;
        drive(1'b0, 32'h8000_0010, 4'h0, 32'h0, 1'b0, 32'hDE22_BE44);
        tick();
        chk("bp_acc0", {31'd0, r_accepted}, 32'd1);
        drive(1'b0, 32'h8000_0014, 4'h0, 32'h0, 1'b0, 32'hCAFE_F00D);
        tick();
        chk("bp_acc1", {31'd0, r_accepted}, 32'd1);
        drive(1'b0, 32'h8000_0FFC, 4'h0, 32'h0, 1'b0, 32'hA5A5_A5A5);
        for (int k = 0; k < 3; k++) begin
            chk("bp_gnt_full", {31'd0, mem_gnt},  32'd0);
            chk("bp_recv_hold", {31'd0, mem_recv}, 32'd1);
            chk("bp_rdata_hold", mem_rdata, 32'hDE22_BE44);
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("bp_gnt_after_ack", {31'd0, mem_gnt}, 32'd1);
        tick();
        chk("bp_acc2", {31'd0, r_accepted}, 32'd1);
        mem_req = 1'b0;
        mem_ack = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("bp_drained", sb.size(), 0);

        // Back-to-back throughput with ack held high
        r_accepts = 0;
        drive(1'b0, 32'h8000_0010, 4'h0, 32'h0, 1'b0, 32'hDE22_BE44);
        tick();
        drive(1'b0, 32'h8000_0014, 4'h0, 32'h0, 1'b0, 32'hCAFE_F00D);
        tick();
        drive(1'b0, 32'h8000_0FFC, 4'h0, 32'h0, 1'b0, 32'hA5A5_A5A5);
        tick();
        drive(1'b0, 32'h8000_0000, 4'h0, 32'h0, 1'b0, 32'h0102_0304);
        tick();
        mem_req = 1'b0;
        chk("b2b_accepts", r_accepts, 4);
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("b2b_drained", sb.size(), 0);

        // Reset mid-flight with two entries queued
        mem_ack = 1'b0;
        drive(1'b0, 32'h8000_0010, 4'h0, 32'h0, 1'b0, 32'hDE22_BE44);
        tick();
        drive(1'b1, 32'h8000_0020, 4'hF, 32'h5555_AAAA, 1'b0, 32'h0);
        tick();
        mem_req = 1'b0;
        chk("rst_queued", sb.size(), 2);
        chk("rst_recv_before", {31'd0, mem_recv}, 32'd1);
        g_resetn = 1'b0;
        #1;
        chk("rst_recv_async", {31'd0, mem_recv}, 32'd0);
        chk("rst_gnt_async",  {31'd0, mem_gnt},  32'd0);
        sb.delete();
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;
        chk("rst_gnt_after", {31'd0, mem_gnt}, 32'd1);
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_no_stale", {31'd0, mem_recv}, 32'd0);
            tick();
        end
        // Write accepted before reset persists
        single('{1'b0, 32'h8000_0020, 4'h0, 32'h0, 1'b0, 32'h5555_AAAA});
        single('{1'b0, 32'h8000_0010, 4'h0, 32'h0, 1'b0, 32'hDE22_BE44});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
